// File: rtl/rs232_echo_ctrl.sv
// Echo sequencer between the quick_rs232 RX/TX FIFOs: pops a byte, drops it on
// a parity/framing error, otherwise pushes byte+INCREMENT into the TX FIFO.
module rs232_echo_ctrl #(
    parameter logic [7:0] INCREMENT = 8'd1,
    parameter int         CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 rx_empty,
    input  logic [7:0]           rx_data,
    input  logic                 rx_err,
    output logic                 rx_rd,
    input  logic                 tx_full,
    input  logic                 tx_almost_full,
    output logic [7:0]           tx_data,
    output logic                 tx_wr,
    input  logic                 rts,
    output logic                 cts,
    output logic                 busy,
    output logic [CNT_WIDTH-1:0] echo_cnt,
    output logic [CNT_WIDTH-1:0] drop_cnt
);

    typedef enum logic [1:0] {
        IDLE,
        POP,
        CAPTURE,
        WRITE
    } state_t;

    state_t               state_reg, state_next;
    logic                 rx_rd_reg, rx_rd_next;
    logic                 tx_wr_reg, tx_wr_next;
    logic                 cts_reg, cts_next;
    logic [7:0]           byte_reg, byte_next;
    logic [CNT_WIDTH-1:0] echo_reg, echo_next;
    logic [CNT_WIDTH-1:0] drop_reg, drop_next;

    // Host handshake input is informational only; it never gates the sequencer.
    logic unused_rts;
    assign unused_rts = rts;

    always_comb begin
        state_next = state_reg;
        rx_rd_next = 1'b0;
        tx_wr_next = 1'b0;
        byte_next  = byte_reg;
        echo_next  = echo_reg;
        drop_next  = drop_reg;
        cts_next   = en & ~tx_almost_full;
        case (state_reg)
            IDLE: begin
                if (en && !rx_empty) begin
                    rx_rd_next = 1'b1;
                    state_next = POP;
                end
            end
            // One cycle of FIFO read latency before rx_data/rx_err are valid.
            POP: begin
                state_next = CAPTURE;
            end
            CAPTURE: begin
                if (rx_err) begin
                    drop_next  = drop_reg + CNT_WIDTH'(1);
                    state_next = IDLE;
                end else begin
                    byte_next  = rx_data + INCREMENT;
                    state_next = WRITE;
                end
            end
            WRITE: begin
                if (!tx_full) begin
                    tx_wr_next = 1'b1;
                    echo_next  = echo_reg + CNT_WIDTH'(1);
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
            rx_rd_reg <= 1'b0;
            tx_wr_reg <= 1'b0;
            cts_reg   <= 1'b0;
            byte_reg  <= 8'h00;
            echo_reg  <= '0;
            drop_reg  <= '0;
        end else begin
            state_reg <= state_next;
            rx_rd_reg <= rx_rd_next;
            tx_wr_reg <= tx_wr_next;
            cts_reg   <= cts_next;
            byte_reg  <= byte_next;
            echo_reg  <= echo_next;
            drop_reg  <= drop_next;
        end
    end

    // tx_data is the held byte register, so it stays stable while TX is full.
    assign rx_rd    = rx_rd_reg;
    assign tx_wr    = tx_wr_reg;
    assign tx_data  = byte_reg;
    assign cts      = cts_reg;
    assign busy     = (state_reg != IDLE);
    assign echo_cnt = echo_reg;
    assign drop_cnt = drop_reg;

endmodule

// File: tb/tb_rs232_echo_ctrl.sv
// Bench for rs232_echo_ctrl: FIFO environment plus a timeline-based reference
// model (cycles since each pop), directed scenarios and a randomized phase.
module tb_rs232_echo_ctrl;

    localparam logic [7:0] INC  = 8'd1;
    localparam int         CW   = 4;
    localparam int         CMOD = 1 << CW;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          en = 1'b0;
    logic          rx_empty = 1'b1;
    logic [7:0]    rx_data = 8'h00;
    logic          rx_err = 1'b0;
    logic          tx_full = 1'b0;
    logic          tx_almost_full = 1'b0;
    logic          rts = 1'b0;
    logic          rx_rd, tx_wr, cts, busy;
    logic [7:0]    tx_data;
    logic [CW-1:0] echo_cnt, drop_cnt;

    always #5 clk = ~clk;

    rs232_echo_ctrl #(.INCREMENT(INC), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst), .en(en), .rx_empty(rx_empty), .rx_data(rx_data),
        .rx_err(rx_err), .rx_rd(rx_rd), .tx_full(tx_full),
        .tx_almost_full(tx_almost_full), .tx_data(tx_data), .tx_wr(tx_wr),
        .rts(rts), .cts(cts), .busy(busy), .echo_cnt(echo_cnt), .drop_cnt(drop_cnt)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    // RX FIFO contents as {err, data}
    logic [8:0] fifo_q[$];
    logic [8:0] held = 9'h0;
    bit         deliver = 0;

    // reference model: age = cycles since the observed pop, -1 when idle
    int         m_age = -1;
    logic       m_err = 1'b0;
    logic [7:0] m_byte = 8'h00;
    int         m_echo = 0;
    int         m_drop = 0;
    bit         live = 0;
    logic       p_en = 1'b0, p_empty = 1'b1, p_full = 1'b0, p_afull = 1'b0;

    logic [7:0] last_tx = 8'h00;
    int         last_rd_cyc = 0, last_wr_cyc = 0, rd_count = 0, wr_count = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_age   = -1;
        m_echo  = 0;
        m_drop  = 0;
        deliver = 0;
        live    = 0;
    endtask

    task automatic step(input bit nen, input bit nfull, input bit nafull, input bit nrst);
        logic       exp_rd, exp_wr;
        logic [7:0] exp_byte;
        @(negedge clk);
        cyc++;
        exp_rd = 1'b0;
        exp_wr = 1'b0;
        if (live) begin
            if (m_age < 0) begin
                if (p_en && !p_empty) begin
                    exp_rd = 1'b1;
                    m_age  = 0;
                end
            end else begin
                m_age++;
                if (m_age == 2 && m_err) begin
                    m_drop++;
                    m_age = -1;
                end else if (m_age >= 3 && !p_full) begin
                    exp_wr = 1'b1;
                    m_echo++;
                    m_age = -1;
                end
            end
        end
        exp_byte = m_byte + INC;
        chk("rx_rd", rx_rd, exp_rd);
        chk("tx_wr", tx_wr, exp_wr);
        chk("busy", busy, m_age >= 0);
        chk("cts", cts, live ? (p_en & ~p_afull) : 1'b0);
        chk("echo_cnt", echo_cnt, m_echo % CMOD);
        chk("drop_cnt", drop_cnt, m_drop % CMOD);
        if (!live)
            chk("tx_data_reset", tx_data, 0);
        else if (exp_wr || m_age >= 2)
            chk("tx_data", tx_data, exp_byte);
        if (tx_wr === 1'b1) begin
            last_tx     = tx_data;
            last_wr_cyc = cyc;
            wr_count++;
        end
        // RX FIFO environment: data appears the cycle after the pop strobe
        if (deliver) begin
            {rx_err, rx_data} = held;
        end else begin
            rx_data = 8'($urandom);
            rx_err  = 1'($urandom);
        end
        deliver = 0;
        if (rx_rd === 1'b1 && rst) begin
            last_rd_cyc = cyc;
            rd_count++;
            chk("pop_when_nonempty", fifo_q.size() != 0, 1);
            if (fifo_q.size() != 0) begin
                held    = fifo_q.pop_front();
                deliver = 1;
                if (exp_rd) {m_err, m_byte} = held;
            end
        end
        en             = nen;
        tx_full        = nfull;
        tx_almost_full = nafull;
        rts            = 1'($urandom);
        rst            = nrst;
        rx_empty       = (fifo_q.size() == 0);
        p_en = nen; p_full = nfull; p_afull = nafull; p_empty = rx_empty;
        live = nrst;
        if (!nrst) model_reset();
    endtask

    task automatic run(input int n, input bit nen, input bit nfull);
        for (int i = 0; i < n; i++) step(nen, nfull, 1'b0, 1'b1);
    endtask

    initial begin
        int base_wr, base_rd;
        bit found;

        // reset state
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);

        // 1: preloaded 0x41 -> 0x42, three cycles after the pop
        fifo_q.push_back({1'b0, 8'h41});
        step(1, 0, 0, 1);
        run(7, 1, 0);
        chk("t1_data", last_tx, 8'h42);
        chk("t1_echo", echo_cnt, 1);
        chk("t1_latency", last_wr_cyc - last_rd_cyc, 3);
        chk("t1_busy", busy, 0);

        // 2: 0xFF wraps to 0x00
        fifo_q.push_back({1'b0, 8'hFF});
        run(8, 1, 0);
        chk("t2_data", last_tx, 8'h00);
        chk("t2_echo", echo_cnt, 2);

        // 3: errored 0x10 dropped, clean 0x20 echoed
        base_wr = wr_count;
        fifo_q.push_back({1'b1, 8'h10});
        fifo_q.push_back({1'b0, 8'h20});
        run(14, 1, 0);
        chk("t3_drop", drop_cnt, 1);
        chk("t3_echo", echo_cnt, 3);
        chk("t3_writes", wr_count - base_wr, 1);
        chk("t3_data", last_tx, 8'h21);

        // 4: TX full holds a pending 0x55
        base_wr = wr_count;
        base_rd = rd_count;
        fifo_q.push_back({1'b0, 8'h54});
        fifo_q.push_back({1'b0, 8'h66});
        run(13, 1, 1);
        chk("t4_hold_no_wr", wr_count - base_wr, 0);
        chk("t4_hold_one_rd", rd_count - base_rd, 1);
        chk("t4_hold_data", tx_data, 8'h55);
        step(1, 0, 0, 1);
        step(1, 0, 0, 1);
        chk("t4_release_wr", wr_count - base_wr, 1);
        chk("t4_release_data", last_tx, 8'h55);
        run(8, 1, 0);
        chk("t4_echo", echo_cnt, 5);
        chk("t4_data2", last_tx, 8'h67);

        // 5: cts follows en & ~almost_full; en=0 blocks pops
        for (int i = 0; i < 6; i++) step(1, 0, i[0], 1);
        base_rd = rd_count;
        for (int i = 0; i < 5; i++) fifo_q.push_back({1'b0, 8'h60 + 8'(i)});
        for (int i = 0; i < 8; i++) step(0, 0, i[0], 1);
        chk("t5_no_pop", rd_count - base_rd, 0);
        chk("t5_queue", fifo_q.size(), 5);
        chk("t5_cts", cts, 0);

        // 6: asynchronous reset while a byte is in CAPTURE
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            step(1, 0, 0, 1);
            if (m_age == 1) found = 1;
        end
        chk("t6_reached_capture", found, 1);
        #1 rst = 1'b0;
        #1;
        chk("t6_rst_rx_rd", rx_rd, 0);
        chk("t6_rst_tx_wr", tx_wr, 0);
        chk("t6_rst_tx_data", tx_data, 0);
        chk("t6_rst_cts", cts, 0);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_echo", echo_cnt, 0);
        model_reset();
        step(1, 0, 0, 0);
        step(1, 0, 0, 1);
        run(20, 1, 0);
        chk("t6_echo", echo_cnt, 4);
        chk("t6_drop", drop_cnt, 0);
        chk("t6_data", last_tx, 8'h65);

        // randomized traffic, including counter wrap and rare resets
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 2) == 0 && fifo_q.size() < 8)
                fifo_q.push_back({($urandom_range(0, 4) == 0), 8'($urandom)});
            step($urandom_range(0, 7) != 0, $urandom_range(0, 2) == 0,
                 1'($urandom), $urandom_range(0, 399) != 0);
        end
        run(12, 1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
